// File: rtl/fp_mul_pkg.sv
// Shared types and defaults for the fp32 multiplier stream front-end.
package fp_mul_pkg;
    localparam int FP32_W          = 32;
    localparam int MUL_LATENCY_DEF = 4;
    localparam int TAG_W_DEF       = 8;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        fp32_t                data;
        logic [TAG_W_DEF-1:0] tag;
    } fp_result_t;
endpackage

// File: rtl/fp_mul_stream_ctrl_if.sv
// Operand/result stream bundle plus the multiplier drive and debug credits.
interface fp_mul_stream_ctrl_if #(
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 8
);
    import fp_mul_pkg::*;

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    fp32_t             in_a;
    fp32_t             in_b;
    logic [TAG_W-1:0]  in_tag;

    fp32_t             mul_ay;
    fp32_t             mul_az;
    logic              mul_ena;
    logic              mul_clr;
    fp32_t             mul_result;

    logic              out_valid;
    logic              out_ready;
    fp32_t             out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [CRED_W-1:0] credits;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, mul_result, out_ready,
        output in_ready, mul_ay, mul_az, mul_ena, mul_clr,
               out_valid, out_data, out_tag, credits
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, mul_result, out_ready,
        input  in_ready, mul_ay, mul_az, mul_ena, mul_clr,
               out_valid, out_data, out_tag, credits
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Synchronous FIFO whose head word, empty, full and count are all registered.
module fp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             empty_q, full_q;
    logic             rd_fire;

    assign rd_fire = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_en   ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_fire);
        // The new head may be the word landing this cycle; bypass it so the
        // output register is valid on the very next cycle.
        if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full_q));
endmodule

// File: rtl/fp_mul_stream_ctrl.sv
// Valid/ready front-end for a fixed-latency fp32 multiplier: tags ride a shift
// register beside the pipe and products land in a credit-reserved result FIFO.
module fp_mul_stream_ctrl
    import fp_mul_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 8,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_mul_stream_ctrl_if.slave  io
);
    localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = FP32_W + TAG_W;

    logic [CRED_W-1:0]      credits_q, credits_d;
    logic [MUL_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [TAG_W-1:0]       tag_sr_q [MUL_LATENCY];
    logic [TAG_W-1:0]       tag_sr_d [MUL_LATENCY];

    logic               accept;
    logic               pop;
    logic               fifo_wr;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CRED_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_rd_data;

    assign io.in_ready = rst_n && (credits_q != '0);
    assign accept      = io.in_valid && io.in_ready;
    assign pop         = io.out_valid && io.out_ready;
    assign fifo_wr     = vld_sr_q[MUL_LATENCY-1];

    assign io.mul_ay  = io.in_a;
    assign io.mul_az  = io.in_b;
    assign io.mul_ena = rst_n;
    assign io.mul_clr = ~rst_n;

    always_comb begin
        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (pop && !accept) begin
            credits_d = credits_q + CRED_W'(1);
        end
        vld_sr_d    = MUL_LATENCY'({vld_sr_q, accept});
        tag_sr_d[0] = io.in_tag;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q <= CRED_W'(FIFO_DEPTH);
            vld_sr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            vld_sr_q  <= vld_sr_d;
        end
    end

    // Tags are only meaningful where vld_sr_q is set, so they need no reset.
    always_ff @(posedge clk) begin
        tag_sr_q <= tag_sr_d;
    end

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({io.mul_result, tag_sr_q[MUL_LATENCY-1]}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign io.out_valid = ~fifo_empty;
    assign io.out_data  = fifo_rd_data[ENTRY_W-1:TAG_W];
    assign io.out_tag   = fifo_rd_data[TAG_W-1:0];
    assign io.credits   = credits_q;

    a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(credits_q) + 32'($countones(vld_sr_q)) + 32'(fifo_count)) == 32'(FIFO_DEPTH));

    a_land_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && fifo_full));
endmodule

// File: tb/tb_fp_mul_stream_ctrl.sv
// Scoreboard bench for fp_mul_stream_ctrl with a behavioural 4-stage multiplier.
module tb_fp_mul_stream_ctrl;
    import fp_mul_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    typedef struct {
        fp_result_t r;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    logic rst_at_edge = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int ready_low_cnt = 0;
    int model_cr = DEPTH;
    logic [31:0] drv_exp = '0;
    exp_t sb_q[$];

    logic [31:0] mul_pipe [LAT];

    fp_mul_stream_ctrl_if #(.TAG_W(8), .FIFO_DEPTH(DEPTH)) io ();

    fp_mul_stream_ctrl #(
        .MUL_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH),
        .TAG_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    // IEEE fp32 product for the operand classes this bench generates.
    function automatic logic [31:0] fp_mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] mp;
        int          e;
        logic [22:0] frac;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf || b_inf) return (a_zero || b_zero) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {s, 31'h0};
        mp = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (mp[47]) begin
            frac = mp[46:24];
            e    = e + 1;
        end else begin
            frac = mp[45:23];
        end
        return {s, e[7:0], frac};
    endfunction

    // Operands with short significands and moderate exponents so products are exact.
    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        if (r[2:0] == 3'd0) begin
            case (r[4:3])
                2'd0:    return 32'h7F800000;
                2'd1:    return 32'h00000000;
                2'd2:    return 32'h80000000;
                default: return 32'h3F800000;
            endcase
        end
        e = 8'(100 + (r[15:8] % 55));
        return {r[31], e, r[22:16], 16'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (io.mul_clr) begin
            for (int i = 0; i < LAT; i++) mul_pipe[i] <= '0;
        end else if (io.mul_ena) begin
            mul_pipe[0] <= fp_mul_ref(io.mul_ay, io.mul_az);
            for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign io.mul_result = mul_pipe[LAT-1];

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = rst_n;
    end

    // Monitor: credit model, output timing and in-order scoreboard.
    always @(negedge clk) begin
        logic exp_rdy, exp_ov, acc, pop;
        exp_t e;
        if (!rst_n) begin
            check("rst_in_ready", io.in_ready, 0);
            check("rst_mul_ena", io.mul_ena, 0);
            check("rst_mul_clr", io.mul_clr, 1);
            if (!rst_at_edge) begin
                check("rst_credits", io.credits, DEPTH);
                check("rst_out_valid", io.out_valid, 0);
            end
            sb_q.delete();
            model_cr = DEPTH;
        end else begin
            exp_rdy = (model_cr != 0);
            check("credits", io.credits, model_cr);
            check("in_ready", io.in_ready, exp_rdy);
            check("mul_ena", io.mul_ena, 1);
            check("mul_ay", io.mul_ay, io.in_a);
            check("mul_az", io.mul_az, io.in_b);
            if (!io.in_ready) ready_low_cnt++;
            exp_ov = (sb_q.size() != 0) && (cyc >= sb_q[0].t + LAT + 1);
            check("out_valid", io.out_valid, exp_ov);
            pop = io.out_valid && io.out_ready;
            if (io.out_valid && sb_q.size() != 0) begin
                check("out_data", io.out_data, sb_q[0].r.data);
                check("out_tag", io.out_tag, sb_q[0].r.tag);
                if (pop) e = sb_q.pop_front();
            end
            acc = io.in_valid && exp_rdy;
            if (acc) begin
                e.r.data = drv_exp;
                e.r.tag  = io.in_tag;
                e.t      = cyc;
                sb_q.push_back(e);
                acc_cnt++;
            end
            model_cr = model_cr - int'(acc) + int'(pop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] tg, input logic [31:0] e);
        io.in_valid = v;
        io.in_a     = a;
        io.in_b     = b;
        io.in_tag   = tg;
        drv_exp     = e;
    endtask

    task automatic drive_rnd();
        logic [31:0] a, b;
        a = rnd_fp();
        b = rnd_fp();
        drive(1'b1, a, b, 8'($urandom), fp_mul_ref(a, b));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
        check(name, sb_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_low;
        rst_n = 1'b0;
        io.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_release", io.in_ready, 1);

        // Single op: 2.0 * 3.0
        io.out_ready = 1'b1;
        drive(1'b1, 32'h40000000, 32'h40400000, 8'h11, 32'h40C00000);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        repeat (8) tick();
        check("single_credits", io.credits, DEPTH);
        check("single_drained", sb_q.size(), 0);

        // Streaming 100 back-to-back pairs: 1.5 * -2.0
        base_acc = acc_cnt;
        base_low = ready_low_cnt;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h3FC00000, 32'hC0000000, 8'(i), 32'hC0400000);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        check("stream_accepts", acc_cnt - base_acc, 100);
        check("stream_ready_low", ready_low_cnt - base_low, 0);
        wait_drain("stream_drain");

        // Backpressure: exactly DEPTH accepts then in_ready low
        io.out_ready = 1'b0;
        base_acc = acc_cnt;
        for (int i = 0; i < 12; i++) begin
            drive_rnd();
            tick();
        end
        check("bp_accepts", acc_cnt - base_acc, DEPTH);
        check("bp_ready_low", io.in_ready, 0);
        drive(1'b0, '0, '0, '0, '0);
        io.out_ready = 1'b1;
        check("bp_ready_at_first_pop", io.in_ready, 0);
        tick();
        check("bp_ready_after_pop", io.in_ready, 1);
        wait_drain("bp_drain");

        // Simultaneous accept and pop with one credit left
        io.out_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_rnd();
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        repeat (7) tick();
        check("sim_credits_before", io.credits, 1);
        check("sim_out_valid", io.out_valid, 1);
        drive_rnd();
        io.out_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0, '0, '0);
        io.out_ready = 1'b0;
        check("sim_credits_after", io.credits, 1);
        tick();
        io.out_ready = 1'b1;
        wait_drain("sim_drain");
        check("sim_credits_final", io.credits, DEPTH);

        // Reset with 2 buffered and 3 in flight
        io.out_ready = 1'b0;
        repeat (2) begin drive_rnd(); tick(); end
        drive(1'b0, '0, '0, '0, '0);
        repeat (6) tick();
        repeat (3) begin drive_rnd(); tick(); end
        drive(1'b0, '0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_credits", io.credits, DEPTH);
        check("post_rst_out_valid", io.out_valid, 0);
        io.out_ready = 1'b1;
        repeat (10) tick();
        drive(1'b1, 32'h40000000, 32'h40400000, 8'h5A, 32'h40C00000);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        wait_drain("post_rst_drain");

        // Special values pass through bit-exact
        drive(1'b1, 32'h7F800000, 32'h00000000, 8'h21, 32'h7FC00000);
        tick();
        drive(1'b1, 32'h80000000, 32'h3F800000, 8'h22, 32'h80000000);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        wait_drain("special_drain");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) < 7) drive_rnd();
            else drive(1'b0, '0, '0, 8'($urandom), '0);
            io.out_ready = ($urandom_range(9) < 6);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        io.out_ready = 1'b1;
        wait_drain("rand_drain");
        check("rand_credits_final", io.credits, DEPTH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_stream_ctrl.md
# fp_mul_stream_ctrl

Valid/ready streaming front-end and result collector for the fixed-latency single-precision DSP multiplier (`sp_mult`, 4-cycle pipeline). It accepts operand pairs with a sideband tag and drives the multiplier's `ay`/`az` inputs with the multiplier permanently enabled. The tag travels alongside the fixed-latency pipe, and each product is realigned with its tag. Products are buffered in a credit-protected FIFO, so downstream backpressure never stalls or drops in-flight multiplier data.

## Interface
- `MUL_LATENCY`, default 4: cycles from operands presented on `mul_ay`/`mul_az` to product valid on `mul_result`.
- `FIFO_DEPTH`, default 8: result buffer entries; power of 2, must be ≥ `MUL_LATENCY`+2.
- `TAG_W`, default 8: sideband tag width.
- `clk` in 1: single clock, shared with the multiplier.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: pair accepted when `in_valid && in_ready`.
- `in_a`, `in_b` in 32: IEEE-754 fp32 operands.
- `in_tag` in `TAG_W`: tag returned with the product.
- `mul_ay`, `mul_az` out 32: to multiplier; combinational copies of `in_a`/`in_b`.
- `mul_ena` out 1: multiplier enable.
- `mul_clr` out 1: multiplier clear (active-high) = `~rst_n`.
- `mul_result` in 32: multiplier product.
- `out_valid` out 1: product available.
- `out_ready` in 1: consumer accepts the product when `out_valid && out_ready`.
- `out_data` out 32: fp32 product.
- `out_tag` out `TAG_W`: tag of `out_data`.
- `credits` out `$clog2(FIFO_DEPTH+1)`: free credits, for debug.

## Operation
- `mul_ena` is 1 whenever `rst_n`=1, otherwise 0. The multiplier pipe never stalls.
- Valid pipe `vld_sr[MUL_LATENCY]` and tag pipe `tag_sr[MUL_LATENCY][TAG_W]` shift every cycle.
- On an accept, stage 0 loads 1 and `in_tag`; otherwise stage 0 loads 0 and the tag is don't-care.
- When the last stage is valid, `{mul_result, tag_sr[last]}` is written to the FIFO in that cycle.
- Credit counter:
  - resets to `FIFO_DEPTH`;
  - −1 on accept, +1 on pop (`out_valid && out_ready`);
  - unchanged when both happen in the same cycle.
- `in_ready = rst_n && (credits != 0)`. This is combinational from the registered counter and does not depend on `in_valid`.
- Invariant: `credits + inflight + fifo_count == FIFO_DEPTH`. As a result the FIFO never overflows. A write while full is an assertion failure.
- Output ordering is strictly the acceptance order. No arithmetic is done in this block; fp32 values, including NaN, Inf, denormals and signed zero, pass through bit-exact.

## Timing
- Accept at cycle t: `mul_result` is valid at t+`MUL_LATENCY` and is written to the FIFO on that edge. `out_valid`=1 at t+`MUL_LATENCY`+1 if the FIFO was empty. Total in→out latency is 5 cycles at default.
- Pop at cycle p: the credit is visible (`in_ready` rises from 0) at p+1.
- Sustained throughput is 1 pair/cycle when `out_ready`=1 continuously, guaranteed by the depth ≥ L+2 rule.
- `out_data`/`out_tag` are stable while `out_valid`=1 and `out_ready`=0.
- Reset values: `in_ready`=0 while `rst_n`=0, and 1 from the first cycle after release. Also: `out_valid`=0, `credits`=`FIFO_DEPTH`, `vld_sr`=0, FIFO empty, `mul_ena`=0, `mul_clr`=1.
- Reset mid-operation: all in-flight products and buffered results are discarded. Nothing appears on the output after release except products of post-reset accepts.
- Full FIFO with `out_ready`=0: `in_ready` falls once credits reach 0. In-flight products still land, because the credits were reserved at accept.

## Structure
- Package `fp_mul_pkg`:
  - `localparam FP32_W = 32`;
  - `localparam MUL_LATENCY_DEF = 4`;
  - `typedef logic [31:0] fp32_t`;
  - `typedef struct packed {fp32_t data; logic [TAG_W-1:0] tag;}` result type, parameterised via the width constant.
- Sub-module `fp_result_fifo`: synchronous FIFO with registered outputs. Same clock and reset; ports `wr_en/wr_data/rd_en/rd_data/empty/full/count`.
- Top level holds the credit counter, valid/tag shift registers and `mul_*` drive. The multiplier instance stays outside this block.

## Test plan
- Single op: `in_a`=0x40000000, `in_b`=0x40400000, tag 0x11 → after 5 cycles `out_data`=0x40C00000 (6.0), `out_tag`=0x11. `credits` returns to 8.
- Streaming: 100 back-to-back pairs `in_a`=0x3FC00000 (1.5), `in_b`=0xC0000000 (−2.0), tags 0..99, `out_ready`=1 → 100 outputs of 0xC0400000 on consecutive cycles, tags in order, `in_ready` never low.
- Backpressure: `out_ready`=0 with `in_valid` held → exactly 8 accepts, then `in_ready`=0. Raise `out_ready` → 8 outputs in order, and `in_ready` reasserts one cycle after the first pop.
- Simultaneous accept and pop at `credits`=1 → `credits` stays 1 and no data is lost or duplicated.
- Reset pulse with 3 products in flight and 2 buffered → no output after release. First new accept yields its product after 5 cycles; `credits`=8 after release.
- Special values: 0x7F800000 × 0x00000000 → 0x7FC00000 (NaN, bit-exact from the multiplier); 0x80000000 × 0x3F800000 → 0x80000000.
